// File: rtl/five_bit_adder.sv
//-----------------------------------------------------------------------------
// five_bit_adder
//
// Registered 5-bit unsigned adder with carry-in and carry-out. The sum is
// formed by a structural ripple chain of five identical full-adder stages
// (bit 0 to bit 4), and the 6-bit result {carry_out, sum} is captured on the
// rising edge of clk. Latency is one cycle, throughput one addition per cycle.
//
// Ports (positional order is fixed):
//   sum        out  5  registered low 5 bits of a + b + carry_in
//   carry_out  out  1  registered MSB carry (bit 5) of a + b + carry_in
//   a          in   5  unsigned addend
//   b          in   5  unsigned addend
//   carry_in   in   1  carry into bit 0
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous, active-high reset (clears sum/carry_out)
//-----------------------------------------------------------------------------

//-----------------------------------------------------------------------------
// full_adder_stage
//
// One bit of the ripple chain.
//
// Ports:
//   a, b   in   1  operand bits
//   c_in   in   1  carry from the previous stage
//   s      out  1  sum bit
//   c_out  out  1  carry to the next stage
//-----------------------------------------------------------------------------
module full_adder_stage (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic s,
   output logic c_out
);

   logic half_sum;

   assign half_sum = a ^ b;
   assign s        = half_sum ^ c_in;
   // Generate when both bits are set, propagate an incoming carry otherwise.
   assign c_out    = (a & b) | (c_in & half_sum);

endmodule : full_adder_stage

module five_bit_adder (
   output logic [4:0] sum,
   output logic       carry_out,
   input  logic [4:0] a,
   input  logic [4:0] b,
   input  logic       carry_in,
   input  logic       clk,
   input  logic       rst
);

   localparam int unsigned WIDTH = 5;

   // carry[i] is the carry into stage i; carry[WIDTH] is the final carry out.
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_comb;

   assign carry[0] = carry_in;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
      full_adder_stage u_stage (
         .a     (a[i]),
         .b     (b[i]),
         .c_in  (carry[i]),
         .s     (sum_comb[i]),
         .c_out (carry[i+1])
      );
   end : g_ripple

   // Output registers. There is no valid/ready: every edge captures a new
   // result, and reset wins over the adder result at that edge.
   // NOTE: reset is sampled only on the clock edge, so rst is deliberately
   // absent from the sensitivity list; a pulse between edges does nothing.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register updating from the
      // pre-edge values, independent of statement order.
      if (rst) begin
         sum       <= '0;
         carry_out <= 1'b0;
      end else begin
         sum       <= sum_comb;
         carry_out <= carry[WIDTH];
      end
   end

endmodule : five_bit_adder

// File: tb/tb_five_bit_adder.sv
//-----------------------------------------------------------------------------
// tb_five_bit_adder
//
// Self-checking bench for five_bit_adder. Operands are driven on the falling
// edge; the expected {carry_out, sum} is pushed to a scoreboard queue at the
// same time and popped for comparison 1 time unit after the following rising
// edge, so every result is checked exactly one edge after its operands.
//-----------------------------------------------------------------------------
module tb_five_bit_adder;

   logic [4:0] sum;
   logic       carry_out;
   logic [4:0] a;
   logic [4:0] b;
   logic       carry_in;
   logic       clk;
   logic       rst;

   int n_tests = 0;
   int n_fail  = 0;

   logic [5:0] sb_q[$];
   logic [5:0] exp_val;
   logic [5:0] last_val;

   five_bit_adder dut (
      .sum       (sum),
      .carry_out (carry_out),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .clk       (clk),
      .rst       (rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one set of inputs at the falling edge, record the expected
   // result, then advance to just after the capturing rising edge.
   task automatic drive(input logic [4:0] va, input logic [4:0] vb,
                        input logic vc, input logic vr);
      logic [5:0] e;
      @(negedge clk);
      a        = va;
      b        = vb;
      carry_in = vc;
      rst      = vr;
      e = vr ? 6'd0 : (6'({1'b0, va}) + 6'({1'b0, vb}) + 6'(vc));
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(5'b11111, 5'b11111, 1'b1, 1'b1);
         exp_val = sb_q.pop_front();
         n_tests++;
         if ({carry_out, sum} !== exp_val) begin
            n_fail++;
            $display("FAIL reset_hold[%0d]: got %b want %b", i, {carry_out, sum}, exp_val);
         end
      end
      drive(5'b11111, 5'b11111, 1'b1, 1'b0);
      exp_val = sb_q.pop_front();
      n_tests++;
      if ({carry_out, sum} !== exp_val) begin
         n_fail++;
         $display("FAIL reset_release: got %b want %b", {carry_out, sum}, exp_val);
      end
   endtask

   task automatic test_basic();
      logic [4:0] va[3] = '{5'b11100, 5'b10101, 5'b00010};
      logic [4:0] vb[3] = '{5'b00011, 5'b01010, 5'b11010};
      for (int i = 0; i < 3; i++) begin
         drive(va[i], vb[i], 1'b0, 1'b0);
         exp_val = sb_q.pop_front();
         n_tests++;
         if ({carry_out, sum} !== exp_val) begin
            n_fail++;
            $display("FAIL basic[%0d]: got %b want %b", i, {carry_out, sum}, exp_val);
         end
      end
   endtask

   task automatic test_carry_ripple();
      drive(5'b11111, 5'b00000, 1'b1, 1'b0);
      exp_val = sb_q.pop_front();
      n_tests++;
      if ({carry_out, sum} !== 6'b100000 || exp_val !== 6'b100000) begin
         n_fail++;
         $display("FAIL ripple_cin: got %b want %b", {carry_out, sum}, 6'b100000);
      end
      drive(5'b11111, 5'b00001, 1'b0, 1'b0);
      exp_val = sb_q.pop_front();
      n_tests++;
      if ({carry_out, sum} !== exp_val) begin
         n_fail++;
         $display("FAIL ripple_b: got %b want %b", {carry_out, sum}, exp_val);
      end
      drive(5'b00000, 5'b00000, 1'b0, 1'b0);
      exp_val = sb_q.pop_front();
      n_tests++;
      if ({carry_out, sum} !== 6'b000000) begin
         n_fail++;
         $display("FAIL zero_case: got %b want %b", {carry_out, sum}, 6'b000000);
      end
   endtask

   // A glitch on a between edges must not be captured.
   task automatic test_sampling();
      @(negedge clk);
      a        = 5'b00001;
      b        = 5'b00001;
      carry_in = 1'b0;
      rst      = 1'b0;
      sb_q.push_back(6'b000010);
      #1 a = 5'b00100;
      #2 a = 5'b00001;
      @(posedge clk);
      #1;
      exp_val = sb_q.pop_front();
      n_tests++;
      if ({carry_out, sum} !== exp_val) begin
         n_fail++;
         $display("FAIL sampling: got %b want %b", {carry_out, sum}, exp_val);
      end
   endtask

   task automatic test_mid_reset();
      logic r[3] = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         drive(5'b00001, 5'b00001, 1'b0, r[i]);
         exp_val = sb_q.pop_front();
         n_tests++;
         if ({carry_out, sum} !== exp_val) begin
            n_fail++;
            $display("FAIL mid_reset[%0d]: got %b want %b", i, {carry_out, sum}, exp_val);
         end
      end
   endtask

   // rst raised between edges leaves outputs alone until the next edge.
   task automatic test_reset_sync();
      drive(5'b01010, 5'b00101, 1'b1, 1'b0);
      last_val = sb_q.pop_front();
      n_tests++;
      if ({carry_out, sum} !== last_val) begin
         n_fail++;
         $display("FAIL sync_pre: got %b want %b", {carry_out, sum}, last_val);
      end
      #1 rst = 1'b1;
      #1;
      n_tests++;
      if ({carry_out, sum} !== last_val) begin
         n_fail++;
         $display("FAIL sync_between: got %b want %b", {carry_out, sum}, last_val);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if ({carry_out, sum} !== 6'b000000) begin
         n_fail++;
         $display("FAIL sync_edge: got %b want %b", {carry_out, sum}, 6'b000000);
      end
   endtask

   task automatic test_exhaustive();
      int errs = 0;
      for (int i = 0; i < 2048; i++) begin
         logic [10:0] v;
         v = 11'(i);
         drive(v[10:6], v[5:1], v[0], 1'b0);
         exp_val = sb_q.pop_front();
         n_tests++;
         if ({carry_out, sum} !== exp_val) begin
            n_fail++;
            errs++;
            if (errs <= 10)
               $display("FAIL exhaustive a=%0d b=%0d cin=%0d: got %0d want %0d",
                        v[10:6], v[5:1], v[0], {carry_out, sum}, exp_val);
         end
      end
   endtask

   initial begin
      a        = '0;
      b        = '0;
      carry_in = 1'b0;
      rst      = 1'b1;
      test_reset();
      test_basic();
      test_carry_ripple();
      test_sampling();
      test_mid_reset();
      test_reset_sync();
      test_exhaustive();
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_five_bit_adder
